gray_seq_decoder: RTL and testbench
===================================

Name: gray_seq_decoder

Overview:
Receive end of the Gray counter LED bus: samples an N-bit Gray word, decodes it to binary and checks that successive values form a legal +1 count sequence. Reports lock status and counts sequence errors. Sits beside the Gray counter system in board-level benches and on-chip self-test, tapping the same leds bus the counter drives.

Parameters:
N, 4, Gray/binary word width
LOCK_COUNT, 3, consecutive legal steps required to assert locked (1..255)
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
gray_in  input  N  Gray word (counter leds bus)
gray_valid  input  1  gray_in sampled on a clk edge where this is high
bin_out  output  N  decoded binary value
bin_valid  output  1  one-cycle strobe, bin_out updated
locked  output  1  sequence tracker locked
err_pulse  output  1  one-cycle strobe per sequence error while locked
err_count  output  ERR_CNT_W  saturating count of sequence errors

Behaviour:
- Reset: async, active-high, one clock, no reset synchroniser inside. While rst=1: bin_out=0, bin_valid=0, locked=0, err_pulse=0, err_count=0, state=S_IDLE, all internal registers 0. Reset mid-stream discards the in-flight sample.
- Stage 1: edge E with gray_valid=1 -> gray_q<=gray_in, v1<=1; else v1<=0.
- Stage 2: edge E+1 -> bin_out<=decode(gray_q), bin_valid<=v1. bin_out holds when v1=0. Latency: 2 edges gray_valid->bin_valid, throughput 1 word/cycle.
- Decode: b[N-1]=g[N-1]; b[i]=b[i+1]^g[i] for i=N-2..0.
- Checker evaluated at the stage-2 edge when v1=1, using the decoded value d and the previous reference ref:
  - step: d == ref+1 mod 2^N (wrap 2^N-1 -> 0 is legal)
  - hold: d == ref (no step, no error, good count unchanged)
  - bad: anything else
- FSM (locked = state==S_LOCK, registered, changes on the same edge as bin_valid):
  - S_IDLE: first sample -> ref<=d, good<=0, go S_ACQ.
  - S_ACQ: step -> good+1; if good+1==LOCK_COUNT go S_LOCK. bad -> ref<=d, good<=0, no error counted. ref<=d on every sample.
  - S_LOCK: step/hold -> ref<=d, stay. bad -> err_pulse=1 for one cycle, err_count+1 saturating at 2^ERR_CNT_W-1, ref<=d, good<=0, go S_ACQ.
- err_pulse and locked fall on the same edge for an error.
- gray_valid gaps of any length are not errors; the sequence resumes from ref.

Optional Feature:
GRAY_BIDIR_EN: when defined, adds output port dir_down (1 bit, reset 0). A decrement (d==ref-1 mod 2^N, including 0 -> 2^N-1) is also a legal step, counts toward lock, and sets dir_down=1; an increment clears it. Direction reversals are legal. When undefined, dir_down is absent and a decrement is bad.

Test Plan:
Reset: hold rst=1 for 3 cycles with gray_in toggling -> all outputs 0, no bin_valid; deassert mid-cycle -> outputs stay 0 until first sample.
Decode/lock: N=4, feed gray 0000,0001,0011,0010 back-to-back -> bin_out 0,1,2,3, each 2 edges after sample; locked rises with bin_valid for value 3; err_count=0.
Wrap: locked, feed gray 1001(14),1000(15),0000(0) -> bin_out 14,15,0, no err_pulse, locked stays 1.
Skip error: locked at bin 3, feed gray 0111(5) -> exactly one err_pulse, err_count=1, locked=0; then 0101(6),0100(7),1100(8) -> locked=1 again.
Saturation + gaps: ERR_CNT_W=2, six lock/error cycles with gray_valid low 5 cycles between samples -> err_count stops at 3, gaps produce no errors.
Bidir (GRAY_BIDIR_EN): locked at 0, feed gray 1000(15) -> no error, dir_down=1; without macro same stimulus -> err_pulse, err_count+1.

Source files
------------

// File: rtl/gray_seq_decoder_if.sv
// ----------------------------------------------------------------------------
// gray_seq_decoder_if
// Bus between a Gray counter LED tap and the gray_seq_decoder checker.
//
// Optional feature macro: GRAY_BIDIR_EN (adds dir_down).
//
// Signals:
//   gray_in    [N]          Gray word from the counter leds bus
//   gray_valid              gray_in is sampled on a clk edge while high
//   bin_out    [N]          decoded binary value
//   bin_valid               one-cycle strobe, bin_out updated
//   locked                  sequence tracker locked
//   err_pulse               one-cycle strobe per sequence error while locked
//   err_count  [ERR_CNT_W]  saturating count of sequence errors
//   dir_down                last legal step was a decrement (GRAY_BIDIR_EN only)
//
// Modports:
//   master : drives the Gray word, observes the checker results
//   slave  : the decoder/checker side
// ----------------------------------------------------------------------------
interface gray_seq_decoder_if #(
    parameter int N         = 4,
    parameter int ERR_CNT_W = 8
);
    logic [N-1:0]         gray_in;
    logic                 gray_valid;
    logic [N-1:0]         bin_out;
    logic                 bin_valid;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_count;
`ifdef GRAY_BIDIR_EN
    logic                 dir_down;
`endif

    modport master (
        output gray_in, gray_valid,
        input  bin_out, bin_valid, locked, err_pulse, err_count
`ifdef GRAY_BIDIR_EN
        , dir_down
`endif
    );

    modport slave (
        input  gray_in, gray_valid,
        output bin_out, bin_valid, locked, err_pulse, err_count
`ifdef GRAY_BIDIR_EN
        , dir_down
`endif
    );
endinterface

// File: rtl/gray_seq_decoder.sv
// ----------------------------------------------------------------------------
// gray_seq_decoder
// Receive end of the Gray counter LED bus. Samples an N-bit Gray word,
// decodes it to binary and checks that successive decoded values form a
// legal +1 count sequence. Reports lock status and counts sequence errors.
//
// Optional feature macro: GRAY_BIDIR_EN
//   When defined, a decrement is also a legal step and dir_down reports the
//   direction of the last step. When undefined, a decrement is an error.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : gray_seq_decoder_if.slave
//          in : gray_in, gray_valid
//          out: bin_out, bin_valid, locked, err_pulse, err_count
//               (+ dir_down with GRAY_BIDIR_EN)
//
// Timing: gray_valid at edge E -> bin_valid/locked/err_pulse at edge E+1.
// ----------------------------------------------------------------------------
module gray_seq_decoder #(
    parameter int N          = 4,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    gray_seq_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [N-1:0]         r_gray_p1;
    logic                 r_vld_p1;
    logic [N-1:0]         r_bin_p2;
    logic                 r_vld_p2;

    state_t               r_state;
    logic [N-1:0]         r_ref;
    logic [7:0]           r_good;
    logic                 r_err_pulse;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    state_t               w_state_nxt;
    logic [N-1:0]         w_ref_nxt;
    logic [7:0]           w_good_nxt;
    logic                 w_err_pulse_nxt;
    logic [ERR_CNT_W-1:0] w_err_cnt_nxt;

    logic [N-1:0]         w_dec;
    logic [N-1:0]         w_ref_inc;
    logic [7:0]           w_good_inc;
    logic                 w_is_inc;
    logic                 w_is_hold;
    logic                 w_step;

`ifdef GRAY_BIDIR_EN
    logic                 r_dir_down;
    logic                 w_dir_nxt;
    logic [N-1:0]         w_ref_dec;
    logic                 w_is_dec;
`endif

    assign w_dec      = gray2bin(r_gray_p1);
    assign w_ref_inc  = r_ref + 1'b1;
    assign w_good_inc = r_good + 8'd1;
    assign w_is_inc   = (w_dec == w_ref_inc);
    assign w_is_hold  = (w_dec == r_ref);

`ifdef GRAY_BIDIR_EN
    assign w_ref_dec  = r_ref - 1'b1;
    assign w_is_dec   = (w_dec == w_ref_dec);
    assign w_step     = w_is_inc | w_is_dec;
`else
    assign w_step     = w_is_inc;
`endif

    // ---- stage 1: capture the Gray word ----
    // ---- stage 2: decoded output and valid strobe ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gray_p1 <= '0;
            r_vld_p1  <= 1'b0;
            r_bin_p2  <= '0;
            r_vld_p2  <= 1'b0;
        end else begin
            r_vld_p1 <= bus.gray_valid;
            if (bus.gray_valid) begin
                r_gray_p1 <= bus.gray_in;
            end
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_bin_p2 <= w_dec;
            end
        end
    end

    // Sequence tracker: evaluated alongside stage 2, only when a sample arrives.
    always_comb begin
        w_state_nxt     = r_state;
        w_ref_nxt       = r_ref;
        w_good_nxt      = r_good;
        w_err_pulse_nxt = 1'b0;
        w_err_cnt_nxt   = r_err_cnt;
`ifdef GRAY_BIDIR_EN
        w_dir_nxt       = r_dir_down;
`endif
        if (r_vld_p1) begin
            w_ref_nxt = w_dec;
            case (r_state)
                S_IDLE: begin
                    w_good_nxt  = 8'd0;
                    w_state_nxt = S_ACQ;
                end
                S_ACQ: begin
                    if (w_step) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == 8'(LOCK_COUNT)) begin
                            w_state_nxt = S_LOCK;
                        end
                    end else if (!w_is_hold) begin
                        // Not yet locked: restart acquisition silently.
                        w_good_nxt = 8'd0;
                    end
                end
                S_LOCK: begin
                    if (!(w_step || w_is_hold)) begin
                        w_err_pulse_nxt = 1'b1;
                        w_err_cnt_nxt   = sat_inc(r_err_cnt);
                        w_good_nxt      = 8'd0;
                        w_state_nxt     = S_ACQ;
                    end
                end
                default: begin
                    w_good_nxt  = 8'd0;
                    w_state_nxt = S_IDLE;
                end
            endcase
`ifdef GRAY_BIDIR_EN
            // Direction only follows legal steps seen after the first sample;
            // increment wins when both match (N=1).
            if (r_state == S_ACQ || r_state == S_LOCK) begin
                if (w_is_inc) begin
                    w_dir_nxt = 1'b0;
                end else if (w_is_dec) begin
                    w_dir_nxt = 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ref       <= '0;
            r_good      <= 8'd0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
`ifdef GRAY_BIDIR_EN
            r_dir_down  <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_ref       <= w_ref_nxt;
            r_good      <= w_good_nxt;
            r_err_pulse <= w_err_pulse_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
`ifdef GRAY_BIDIR_EN
            r_dir_down  <= w_dir_nxt;
`endif
        end
    end

    assign bus.bin_out   = r_bin_p2;
    assign bus.bin_valid = r_vld_p2;
    assign bus.locked    = (r_state == S_LOCK);
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_count = r_err_cnt;
`ifdef GRAY_BIDIR_EN
    assign bus.dir_down  = r_dir_down;
`endif

endmodule

// File: tb/tb_gray_seq_decoder.sv
// ----------------------------------------------------------------------------
// tb_gray_seq_decoder
// Directed bench for gray_seq_decoder (N=4, LOCK_COUNT=3, ERR_CNT_W=2).
// Inputs change on the falling edge; outputs are checked 1 time unit after
// the rising edge that produced them.
// ----------------------------------------------------------------------------
module tb_gray_seq_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    gray_seq_decoder_if #(.N(4), .ERR_CNT_W(2)) bus_if ();

    gray_seq_decoder #(
        .N          (4),
        .LOCK_COUNT (3),
        .ERR_CNT_W  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, return just after the rising edge.
    task automatic cyc(input logic [3:0] g, input logic v);
        @(negedge clk);
        bus_if.gray_in    = g;
        bus_if.gray_valid = v;
        @(posedge clk);
        #1;
    endtask

    // Present one sample, then idle one cycle so its result is visible.
    task automatic feed(input logic [3:0] b);
        cyc(b ^ (b >> 1), 1'b1);
        cyc(4'd0, 1'b0);
    endtask

    initial begin
        logic [3:0] b;
        logic [3:0] s;
        int         exp_cnt;

        bus_if.gray_in    = 4'd0;
        bus_if.gray_valid = 1'b0;

        // Reset held with the bus toggling and valid asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_if.gray_in    = 4'(i * 5 + 3);
            bus_if.gray_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("rst_bin_valid", bus_if.bin_valid, 0);
            chk("rst_bin_out",   bus_if.bin_out,   0);
            chk("rst_locked",    bus_if.locked,    0);
            chk("rst_err_pulse", bus_if.err_pulse, 0);
            chk("rst_err_count", bus_if.err_count, 0);
        end
        @(negedge clk);
        rst               = 1'b0;
        bus_if.gray_valid = 1'b0;
        cyc(4'd0, 1'b0);
        chk("post_rst_bin_valid", bus_if.bin_valid, 0);
        chk("post_rst_bin_out",   bus_if.bin_out,   0);
        chk("post_rst_locked",    bus_if.locked,    0);

        // Decode and lock: Gray 0,1,3,2 -> binary 0,1,2,3.
        cyc(4'b0000, 1'b1);
        chk("lat_no_early_valid", bus_if.bin_valid, 0);
        cyc(4'b0001, 1'b1);
        chk("dec0_valid",  bus_if.bin_valid, 1);
        chk("dec0_bin",    bus_if.bin_out,   0);
        chk("dec0_locked", bus_if.locked,    0);
        cyc(4'b0011, 1'b1);
        chk("dec1_bin",    bus_if.bin_out,   1);
        chk("dec1_locked", bus_if.locked,    0);
        cyc(4'b0010, 1'b1);
        chk("dec2_bin",    bus_if.bin_out,   2);
        chk("dec2_locked", bus_if.locked,    0);
        cyc(4'd0, 1'b0);
        chk("dec3_valid",     bus_if.bin_valid, 1);
        chk("dec3_bin",       bus_if.bin_out,   3);
        chk("dec3_locked",    bus_if.locked,    1);
        chk("dec3_err_count", bus_if.err_count, 0);
        chk("dec3_err_pulse", bus_if.err_pulse, 0);
        cyc(4'd0, 1'b0);
        chk("hold_valid_low", bus_if.bin_valid, 0);
        chk("hold_bin",       bus_if.bin_out,   3);

        // Skip error: 3 -> 5 while locked, then relock on 6,7,8.
        cyc(4'b0111, 1'b1);
        cyc(4'd0, 1'b0);
        chk("skip_bin",       bus_if.bin_out,   5);
        chk("skip_err_pulse", bus_if.err_pulse, 1);
        chk("skip_err_count", bus_if.err_count, 1);
        chk("skip_locked",    bus_if.locked,    0);
        cyc(4'd0, 1'b0);
        chk("skip_pulse_one_cycle", bus_if.err_pulse, 0);
        chk("skip_err_count_hold",  bus_if.err_count, 1);
        cyc(4'b0101, 1'b1);
        cyc(4'b0100, 1'b1);
        chk("relock6_bin",    bus_if.bin_out, 6);
        chk("relock6_locked", bus_if.locked,  0);
        cyc(4'b1100, 1'b1);
        chk("relock7_bin",    bus_if.bin_out, 7);
        chk("relock7_locked", bus_if.locked,  0);
        cyc(4'd0, 1'b0);
        chk("relock8_bin",       bus_if.bin_out,   8);
        chk("relock8_locked",    bus_if.locked,    1);
        chk("relock8_err_count", bus_if.err_count, 1);

        // Walk 9..13 back-to-back, then wrap 14,15,0.
        for (int k = 9; k <= 13; k++) begin
            b = 4'(k);
            cyc(b ^ (b >> 1), 1'b1);
        end
        cyc(4'b1001, 1'b1);
        chk("walk13_bin",    bus_if.bin_out, 13);
        chk("walk13_locked", bus_if.locked,  1);
        cyc(4'b1000, 1'b1);
        chk("wrap14_bin",    bus_if.bin_out,   14);
        chk("wrap14_pulse",  bus_if.err_pulse, 0);
        cyc(4'b0000, 1'b1);
        chk("wrap15_bin",    bus_if.bin_out,   15);
        chk("wrap15_pulse",  bus_if.err_pulse, 0);
        cyc(4'd0, 1'b0);
        chk("wrap0_bin",       bus_if.bin_out,   0);
        chk("wrap0_pulse",     bus_if.err_pulse, 0);
        chk("wrap0_locked",    bus_if.locked,    1);
        chk("wrap0_err_count", bus_if.err_count, 1);

        // Decrement 0 -> 15 while locked.
        cyc(4'b1000, 1'b1);
        cyc(4'd0, 1'b0);
        chk("down_bin", bus_if.bin_out, 15);
`ifdef GRAY_BIDIR_EN
        chk("down_pulse",     bus_if.err_pulse, 0);
        chk("down_locked",    bus_if.locked,    1);
        chk("down_dir",       bus_if.dir_down,  1);
        chk("down_err_count", bus_if.err_count, 1);
        exp_cnt = 1;
`else
        chk("down_pulse",     bus_if.err_pulse, 1);
        chk("down_locked",    bus_if.locked,    0);
        chk("down_err_count", bus_if.err_count, 2);
        exp_cnt = 2;
`endif
        cyc(4'd0, 1'b0);

        // Six lock/error rounds, 5 idle cycles after every sample.
        s = 4'd15;
        for (int r = 0; r < 6; r++) begin
            for (int j = 1; j <= 3; j++) begin
                feed(4'(s + 4'(j)));
                chk("sat_step_bin",   bus_if.bin_out,   32'(4'(s + 4'(j))));
                chk("sat_step_pulse", bus_if.err_pulse, 0);
                if (j == 3) begin
                    chk("sat_locked", bus_if.locked, 1);
                end
`ifdef GRAY_BIDIR_EN
                if (r == 0 && j == 1) begin
                    chk("up_clears_dir", bus_if.dir_down, 0);
                end
`endif
                repeat (4) cyc(4'd0, 1'b0);
                chk("gap_pulse", bus_if.err_pulse, 0);
                chk("gap_valid", bus_if.bin_valid, 0);
            end
            feed(4'(s + 4'd5));
            exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
            chk("sat_err_pulse", bus_if.err_pulse, 1);
            chk("sat_err_locked", bus_if.locked,   0);
            chk("sat_err_count", bus_if.err_count, 32'(exp_cnt));
            repeat (4) cyc(4'd0, 1'b0);
            chk("sat_gap_pulse", bus_if.err_pulse, 0);
            s = 4'(s + 4'd5);
        end
        chk("sat_final_count", bus_if.err_count, 3);

        // Asynchronous reset clears outputs without a clock edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_bin",       bus_if.bin_out,   0);
        chk("async_rst_err_count", bus_if.err_count, 0);
        chk("async_rst_locked",    bus_if.locked,    0);
        chk("async_rst_valid",     bus_if.bin_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
